// File: rtl/rf_cmd_pkg.sv
// Purpose : shared command codes, FSM state encoding and default timeouts for rf_cmd_ctrl.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package rf_cmd_pkg;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  localparam int DEF_FRAME_TIMEOUT = 1024;
  localparam int DEF_RD_TIMEOUT    = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_PUSH
  } state_t;

endpackage

// File: rtl/rf_cmd_timer.sv
// Purpose : loadable saturating down-counter; 'expired' flags TIMEOUT enabled cycles since the last load.
// Latency : expired is combinational from the count; load takes effect at the next edge.
// Backpressure: none.
// Ports   : i_clk, i_reset (async active-low), load (restart), en (count this cycle), expired (out).
module rf_cmd_timer
  import rf_cmd_pkg::*;
#(
  parameter int TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT) + 1;
  // Loading TIMEOUT-1 makes the flag rise in the TIMEOUT-th enabled cycle after the load edge.
  localparam logic [W-1:0] RELOAD = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = en && (count == '0);

endmodule

// File: rtl/rf_cmd_ctrl.sv
// Purpose : parses UART RX command frames (AA addr data / BB addr), drives register-file strobes and pushes read data to TX.
// Latency : every output is registered; strobes appear one cycle after the byte/valid/edge that causes them.
// Backpressure: TX push stalls indefinitely while i_TX_Full is high; RX bytes that arrive mid-read are dropped with an error pulse.
// Ports   : i_clk, i_reset (async active-low); RX byte in (i_RX_Data/i_RX_Valid); register file
//           (o_Address, o_WrEn, o_RdEn, o_WrData, i_RdData, i_RdData_valid); TX (o_TX_Data, o_TX_Valid, i_TX_Full);
//           status (o_busy, o_cmd_error).
module rf_cmd_ctrl
  import rf_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int FRAME_TIMEOUT = DEF_FRAME_TIMEOUT,
  parameter int RD_TIMEOUT    = DEF_RD_TIMEOUT
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_RX_Data,
  input  logic                  i_RX_Valid,
  input  logic [DATA_WIDTH-1:0] i_RdData,
  input  logic                  i_RdData_valid,
  input  logic                  i_TX_Full,
  output logic [ADDR_WIDTH-1:0] o_Address,
  output logic                  o_WrEn,
  output logic                  o_RdEn,
  output logic [DATA_WIDTH-1:0] o_WrData,
  output logic [DATA_WIDTH-1:0] o_TX_Data,
  output logic                  o_TX_Valid,
  output logic                  o_busy,
  output logic                  o_cmd_error
);

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] pend_addr, pend_addr_n;  // write address held until the data byte lands
  logic [DATA_WIDTH-1:0] cap, cap_n;              // captured read data
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdat_n, txdat_n;
  logic                  wr_n, rd_n, txv_n, err_n;

  logic frame_en, frame_exp;
  logic rd_load, rd_en, rd_exp;
  logic addr_ok;

  assign addr_ok  = (i_RX_Data[DATA_WIDTH-1:ADDR_WIDTH] == '0);
  assign frame_en = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR);
  assign rd_en    = (state == RD_WAIT);

  // Any received byte restarts the inter-byte timer; it only counts inside a frame.
  rf_cmd_timer #(.TIMEOUT(FRAME_TIMEOUT)) u_frame_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .load    (i_RX_Valid),
    .en      (frame_en),
    .expired (frame_exp)
  );

  rf_cmd_timer #(.TIMEOUT(RD_TIMEOUT)) u_rd_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .load    (rd_load),
    .en      (rd_en),
    .expired (rd_exp)
  );

  always_comb begin
    state_n     = state;
    pend_addr_n = pend_addr;
    cap_n       = cap;
    addr_n      = o_Address;
    wdat_n      = o_WrData;
    txdat_n     = o_TX_Data;
    wr_n        = 1'b0;
    rd_n        = 1'b0;
    txv_n       = 1'b0;
    err_n       = 1'b0;
    rd_load     = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_RX_Valid) begin
          if (i_RX_Data == DATA_WIDTH'(CMD_WR))      state_n = WR_ADDR;
          else if (i_RX_Data == DATA_WIDTH'(CMD_RD)) state_n = RD_ADDR;
          else                                       err_n   = 1'b1;
        end
      end
      WR_ADDR: begin
        if (i_RX_Valid) begin
          if (addr_ok) begin
            pend_addr_n = i_RX_Data[ADDR_WIDTH-1:0];
            state_n     = WR_DATA;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end else if (frame_exp) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      WR_DATA: begin
        if (i_RX_Valid) begin
          addr_n  = pend_addr;
          wdat_n  = i_RX_Data;
          wr_n    = 1'b1;
          state_n = IDLE;
        end else if (frame_exp) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      RD_ADDR: begin
        if (i_RX_Valid) begin
          if (addr_ok) begin
            addr_n  = i_RX_Data[ADDR_WIDTH-1:0];
            rd_n    = 1'b1;
            rd_load = 1'b1;
            state_n = RD_WAIT;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end else if (frame_exp) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      RD_WAIT: begin
        if (i_RX_Valid) err_n = 1'b1;  // byte dropped, read continues
        // Returned data wins over a timeout that expires in the same cycle.
        if (i_RdData_valid) begin
          cap_n   = i_RdData;
          state_n = TX_PUSH;
        end else if (rd_exp) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      TX_PUSH: begin
        if (i_RX_Valid) err_n = 1'b1;
        if (!i_TX_Full) begin
          txdat_n = cap;
          txv_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      pend_addr   <= '0;
      cap         <= '0;
      o_Address   <= '0;
      o_WrData    <= '0;
      o_TX_Data   <= '0;
      o_WrEn      <= 1'b0;
      o_RdEn      <= 1'b0;
      o_TX_Valid  <= 1'b0;
      o_cmd_error <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_n;
      pend_addr   <= pend_addr_n;
      cap         <= cap_n;
      o_Address   <= addr_n;
      o_WrData    <= wdat_n;
      o_TX_Data   <= txdat_n;
      o_WrEn      <= wr_n;
      o_RdEn      <= rd_n;
      o_TX_Valid  <= txv_n;
      o_cmd_error <= err_n;
      o_busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
module tb_rf_cmd_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int FT = 1024;
  localparam int RT = 4;
  localparam logic [7:0] B_WR = 8'hAA;
  localparam logic [7:0] B_RD = 8'hBB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] rx_data;
  logic          rx_vld;
  logic [DW-1:0] rd_data;
  logic          rd_vld;
  logic          tx_full;
  logic [AW-1:0] o_address;
  logic          o_wren, o_rden, o_txv, o_err, o_busy;
  logic [DW-1:0] o_wrdata, o_txdata;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: bytes of the frame currently being assembled.
  logic [7:0] frm[$];
  logic [7:0] q[$];
  bit         issued_read;
  logic [7:0] cmd, adr, dat;

  rf_cmd_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_TIMEOUT(FT), .RD_TIMEOUT(RT)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_RX_Data      (rx_data),
    .i_RX_Valid     (rx_vld),
    .i_RdData       (rd_data),
    .i_RdData_valid (rd_vld),
    .i_TX_Full      (tx_full),
    .o_Address      (o_address),
    .o_WrEn         (o_wren),
    .o_RdEn         (o_rden),
    .o_WrData       (o_wrdata),
    .o_TX_Data      (o_txdata),
    .o_TX_Valid     (o_txv),
    .o_busy         (o_busy),
    .o_cmd_error    (o_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Flags packed as {wren, rden, tx_valid, cmd_error, busy}.
  task automatic expect_flags(input string tag, input bit wr, input bit rd, input bit tx,
                              input bit er, input bit busy);
    check(tag, {27'd0, o_wren, o_rden, o_txv, o_err, o_busy}, {27'd0, wr, rd, tx, er, busy});
  endtask

  // Idle cycles between bytes; stray read-valid pulses must be ignored here.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      rd_vld  = 1'($urandom_range(0, 1));
      rd_data = 8'($urandom);
      tick();
      rd_vld = 1'b0;
      expect_flags("gap", 0, 0, 0, 0, frm.size() != 0);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit wr_e, rd_e, er_e;
    wr_e = 0; rd_e = 0; er_e = 0; issued_read = 0;
    rx_data = b;
    rx_vld  = 1'b1;
    tick();
    rx_vld  = 1'b0;
    rx_data = 8'($urandom);
    frm.push_back(b);
    if (frm[0] != B_WR && frm[0] != B_RD)           er_e = 1;
    else if (frm.size() >= 2 && frm[1] >= 2 ** AW)  er_e = 1;
    else if (frm[0] == B_WR && frm.size() == 3)     wr_e = 1;
    else if (frm[0] == B_RD && frm.size() == 2)     rd_e = 1;
    expect_flags("byte", wr_e, rd_e, 0, er_e, !(er_e || wr_e));
    if (wr_e) begin
      check("wr_addr", 32'(o_address), 32'(frm[1]));
      check("wr_data", 32'(o_wrdata), 32'(frm[2]));
    end
    if (rd_e) begin
      check("rd_addr", 32'(o_address), 32'(frm[1]));
      issued_read = 1;
    end
    if (er_e || wr_e || rd_e) frm.delete();
  endtask

  // Read data arrives in wait cycle k (k > RT means never); TX is full for full_n cycles.
  task automatic read_return(input int k, input int full_n, input logic [7:0] d, input bit drop);
    bit dropped;
    for (int c = 1; c <= RT; c++) begin
      dropped = drop && (c == 1) && (k >= 2);
      if (c == k) begin rd_vld = 1'b1; rd_data = d; end
      if (dropped) begin rx_vld = 1'b1; rx_data = 8'($urandom); end
      tick();
      rd_vld = 1'b0;
      rx_vld = 1'b0;
      if (c == k) begin
        expect_flags("rd_capture", 0, 0, 0, 0, 1);
        break;
      end else if (c == RT) begin
        expect_flags("rd_timeout", 0, 0, 0, 1, 0);
        return;
      end else begin
        expect_flags("rd_wait", 0, 0, 0, dropped, 1);
      end
    end
    for (int f = 0; f < full_n; f++) begin
      tx_full = 1'b1;
      tick();
      expect_flags("tx_hold", 0, 0, 0, 0, 1);
    end
    tx_full = 1'b0;
    tick();
    expect_flags("tx_push", 0, 0, 1, 0, 0);
    check("tx_data", 32'(o_txdata), 32'(d));
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_data = '0;
    rx_vld  = 1'b0;
    rd_data = '0;
    rd_vld  = 1'b0;
    tx_full = 1'b0;
    issued_read = 0;

    repeat (3) @(posedge clk);
    #1;
    expect_flags("reset_flags", 0, 0, 0, 0, 0);
    check("reset_addr", 32'(o_address), 32'd0);
    check("reset_wdata", 32'(o_wrdata), 32'd0);
    check("reset_txdata", 32'(o_txdata), 32'd0);
    #2 rst_n = 1'b1;

    // Basic write and strobe cleanliness afterwards.
    send(8'hAA); send(8'h05); send(8'h3C);
    gap(2);

    // Nominal read, then the same read against a full TX FIFO.
    send(8'hBB); send(8'h03);
    read_return(2, 0, 8'h20, 0);
    send(8'hBB); send(8'h03);
    read_return(2, 10, 8'h20, 0);

    // Bad command, bad address, then a good write back-to-back.
    send(8'h55);
    send(8'hAA); send(8'h12);
    send(8'hAA); send(8'h01); send(8'hFF);

    // Inter-byte timeout abandons the frame; the next byte is a command.
    send(8'hAA); send(8'h02);
    for (int i = 1; i <= FT; i++) begin
      tick();
      expect_flags("frame_timeout", 0, 0, 0, i == FT, i < FT);
    end
    frm.delete();
    send(8'h3C);

    // Read with no returned data.
    send(8'hBB); send(8'h07);
    read_return(RT + 1, 0, 8'h00, 0);

    // Reset mid-frame, then a clean frame.
    send(8'hAA);
    rst_n = 1'b0;
    #2;
    expect_flags("midreset_flags", 0, 0, 0, 0, 0);
    check("midreset_addr", 32'(o_address), 32'd0);
    check("midreset_wdata", 32'(o_wrdata), 32'd0);
    check("midreset_txdata", 32'(o_txdata), 32'd0);
    frm.delete();
    #2 rst_n = 1'b1;
    send(8'hAA); send(8'h07); send(8'h5A);

    // Randomized frames of all kinds with random gaps, latencies and backpressure.
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: cmd = B_WR;
        4, 5, 6, 7: cmd = B_RD;
        default: begin
          cmd = 8'($urandom);
          while (cmd == B_WR || cmd == B_RD) cmd = 8'($urandom);
        end
      endcase
      if ($urandom_range(0, 4) == 0) adr = {4'($urandom_range(1, 15)), 4'($urandom)};
      else                           adr = 8'($urandom_range(0, 15));
      dat = 8'($urandom);
      q.delete();
      q.push_back(cmd); q.push_back(adr); q.push_back(dat);
      for (int j = 0; j < 3; j++) begin
        gap($urandom_range(0, 2));
        send(q[j]);
        if (issued_read)
          read_return($urandom_range(1, RT + 1), $urandom_range(0, 3), 8'($urandom),
                      1'($urandom_range(0, 1)));
        if (frm.size() == 0) break;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_cmd_ctrl.md
Name: rf_cmd_ctrl

Overview:
Command controller sitting directly upstream of the register file. It parses byte frames from the UART RX path and drives the register file's address, write-enable, read-enable and write-data inputs. It captures read data returned by the register file and pushes it into the UART TX FIFO. It also flags malformed, timed-out or dropped frames.

Parameters:
ADDR_WIDTH, 4, register-file address bits; depth = 2**ADDR_WIDTH
DATA_WIDTH, 8, byte width of RX/TX and register data
FRAME_TIMEOUT, 1024, max idle cycles between bytes of one frame
RD_TIMEOUT, 4, max cycles waiting for i_RdData_valid after o_RdEn

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-low reset
i_RX_Data  in  DATA_WIDTH  received byte
i_RX_Valid  in  1  one-cycle pulse, i_RX_Data valid
i_RdData  in  DATA_WIDTH  register-file read data
i_RdData_valid  in  1  register-file read data valid (one-cycle pulse)
i_TX_Full  in  1  TX FIFO full
o_Address  out  ADDR_WIDTH  register-file address
o_WrEn  out  1  register-file write strobe
o_RdEn  out  1  register-file read strobe
o_WrData  out  DATA_WIDTH  register-file write data
o_TX_Data  out  DATA_WIDTH  byte pushed to TX FIFO
o_TX_Valid  out  1  TX FIFO push strobe
o_busy  out  1  high whenever the controller is not in IDLE
o_cmd_error  out  1  one-cycle error pulse

Behaviour:
- Reset: state IDLE; all outputs 0; timers and capture register 0. Reset mid-frame aborts the frame and produces no strobes.
- All outputs are registered. o_WrEn, o_RdEn, o_TX_Valid and o_cmd_error are single-cycle pulses. o_Address and o_WrData hold their last value between pulses.
- Commands (first byte of a frame):
  - CMD_WR = 0xAA: frame is addr, data.
  - CMD_RD = 0xBB: frame is addr.
  - Any other first byte in IDLE: o_cmd_error pulse, stay in IDLE.
- Address byte: bits above ADDR_WIDTH-1 must be 0. Otherwise: o_cmd_error pulse, return to IDLE, no strobe.
- States and transitions:
  - IDLE -(0xAA)-> WR_ADDR -(addr)-> WR_DATA -(data)-> IDLE.
  - IDLE -(0xBB)-> RD_ADDR -(addr)-> RD_WAIT -(i_RdData_valid)-> TX_PUSH -(!i_TX_Full)-> IDLE.
- Write: at the edge where the data byte is sampled in WR_DATA, register o_Address, o_WrData and o_WrEn=1. The strobe is visible for exactly one cycle, then the FSM is back in IDLE.
- Read issue: at the edge where the address byte is sampled in RD_ADDR, register o_Address and o_RdEn=1 for one cycle, then enter RD_WAIT.
- Read return:
  - In RD_WAIT, capture i_RdData on the first cycle i_RdData_valid=1 and go to TX_PUSH. Nominal: valid is seen 2 edges after the address byte.
  - A wait timer counts cycles in RD_WAIT. If RD_TIMEOUT expires: o_cmd_error pulse, IDLE, nothing pushed.
- TX push: in TX_PUSH, wait while i_TX_Full=1 (no timeout). At the first edge with i_TX_Full=0: o_TX_Data=captured, o_TX_Valid=1 for one cycle, go to IDLE.
- Frame timeout:
  - In WR_ADDR, WR_DATA and RD_ADDR, a counter reloads on each i_RX_Valid.
  - If it reaches FRAME_TIMEOUT with no byte: o_cmd_error pulse, IDLE, no strobe.
- RX bytes arriving in RD_WAIT or TX_PUSH are dropped with an o_cmd_error pulse. The state is unaffected.
- i_RdData_valid outside RD_WAIT is ignored.
- Back-to-back frames: a command byte may arrive in the cycle immediately after the FSM returns to IDLE and is accepted.
- Timer widths: $clog2 of the respective timeout + 1. Counters saturate and never wrap.

Decomposition:
- Package rf_cmd_pkg holds:
  - constants CMD_WR=8'hAA and CMD_RD=8'hBB;
  - the state enum typedef (IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_PUSH);
  - default timeout constants.
- One sub-module is natural: rf_cmd_timer, a loadable saturating down-counter with an expire flag. It is instantiated twice, once for the frame timeout and once for the read timeout.
- The FSM and datapath stay in the top module.

Test Plan:
- RX AA,05,3C -> exactly one o_WrEn pulse with o_Address=5, o_WrData=0x3C one cycle after the third byte; o_busy drops the same cycle; no o_TX_Valid.
- RX BB,03; model returns i_RdData=0x20 with valid 2 cycles after the address byte -> o_RdEn pulse with o_Address=3, then o_TX_Valid with o_TX_Data=0x20.
- Same read with i_TX_Full held high 10 cycles -> no push while full; single push of 0x20 the cycle after i_TX_Full falls.
- RX 0x55, then AA,12 -> error on 0x55; error on address 0x12 (upper bits set), no o_WrEn; next AA,01,FF writes correctly.
- RX AA,02, then silence for FRAME_TIMEOUT cycles -> one o_cmd_error pulse, return to IDLE; a later data byte is treated as a command byte (error).
- Read with no i_RdData_valid -> o_cmd_error after RD_TIMEOUT cycles, no push. Then assert i_reset mid-frame after AA -> all outputs 0; next frame works.
